// File: rtl/spectrum_bands.sv
// Folds each spectrum frame into 16 equal bands and tracks per-band peak-hold levels with linear decay.
// Publishes a bar-graph LED mask plus the dominant band index and its level once per frame.
module spectrum_bands #(
  parameter int NUM_BINS = 512,
  parameter int DECAY    = 4,
  parameter bit SKIP_DC  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic        freq_valid,
  input  logic [9:0]  freq_addr,
  input  logic [7:0]  freq_data,
  input  logic [7:0]  thresh,
  output logic [15:0] led,
  output logic [3:0]  peak_band,
  output logic [7:0]  peak_level,
  output logic        frame_done,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for frame_start, samples ignored
  // ACCUM  | folding bins into cur[] band maxima
  // COMMIT | 16 cycles, band k decays/merges into hold[k]
  // DONE   | one cycle, outputs registered, frame_done pulsed
  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT, DONE} state_t;

  localparam int          SHIFT   = $clog2(NUM_BINS / 16);
  localparam logic [10:0] NB      = 11'(NUM_BINS);
  localparam logic [9:0]  LAST    = 10'(NUM_BINS - 1);
  localparam logic [7:0]  DEC     = 8'(DECAY);

  state_t      state, state_nxt;
  logic [7:0]  cur  [16];
  logic [7:0]  hold [16];
  logic [3:0]  k;
  logic        pending;
  logic [3:0]  best_idx;
  logic [7:0]  best_lvl;

  logic [9:0]  addr_shift;
  logic [3:0]  band;
  logic        sample_ok;
  logic        last_bin;
  logic [7:0]  hold_k;
  logic [7:0]  cur_k;
  logic [7:0]  decayed;
  logic [7:0]  hold_new;

  assign addr_shift = freq_addr >> SHIFT;
  assign band       = addr_shift[3:0];
  assign sample_ok  = freq_valid && ({1'b0, freq_addr} < NB) &&
                      !(SKIP_DC && (freq_addr == 10'd0));
  assign last_bin   = freq_valid && (freq_addr == LAST);
  assign hold_k     = hold[k];
  assign cur_k      = cur[k];
  assign decayed    = (hold_k > DEC) ? (hold_k - DEC) : 8'd0;
  assign hold_new   = (cur_k > decayed) ? cur_k : decayed;
  assign busy       = (state == COMMIT) || (state == DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (frame_start) state_nxt = ACCUM;
      ACCUM:  if (last_bin) state_nxt = COMMIT;
      COMMIT: if (k == 4'd15) state_nxt = DONE;
      DONE:   state_nxt = (pending || frame_start) ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        cur[i]  <= '0;
        hold[i] <= '0;
      end
      k          <= '0;
      pending    <= 1'b0;
      best_idx   <= '0;
      best_lvl   <= '0;
      led        <= '0;
      peak_band  <= '0;
      peak_level <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start)
            for (int i = 0; i < 16; i++) cur[i] <= '0;
        end
        ACCUM: begin
          // A start together with the last bin closes this frame and queues the next.
          if (frame_start && !last_bin) begin
            for (int i = 0; i < 16; i++) cur[i] <= '0;
          end else begin
            if (sample_ok && (freq_data > cur[band])) cur[band] <= freq_data;
            if (last_bin) begin
              k <= '0;
              if (frame_start) pending <= 1'b1;
            end
          end
        end
        COMMIT: begin
          hold[k] <= hold_new;
          cur[k]  <= '0;
          if ((k == 4'd0) || (hold_new > best_lvl)) begin
            best_idx <= k;
            best_lvl <= hold_new;
          end
          k <= k + 4'd1;
          if (frame_start) pending <= 1'b1;
        end
        DONE: begin
          for (int i = 0; i < 16; i++) led[i] <= (hold[i] > thresh);
          peak_band  <= best_idx;
          peak_level <= best_lvl;
          frame_done <= 1'b1;
          pending    <= 1'b0;
          if (pending || frame_start)
            for (int i = 0; i < 16; i++) cur[i] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_bands.sv
// Directed bench for spectrum_bands: a table of whole frames with hand-computed outputs,
// then hand-written sequences for restart, pending start and mid-commit reset.
module tb_spectrum_bands;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        freq_valid = 1'b0;
  logic [9:0]  freq_addr = '0;
  logic [7:0]  freq_data = '0;
  logic [7:0]  thresh = '0;
  logic [15:0] led;
  logic [3:0]  peak_band;
  logic [7:0]  peak_level;
  logic        frame_done;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  spectrum_bands dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .freq_valid(freq_valid), .freq_addr(freq_addr), .freq_data(freq_data),
    .thresh(thresh), .led(led), .peak_band(peak_band), .peak_level(peak_level),
    .frame_done(frame_done), .busy(busy)
  );

  always #20 clk = ~clk;

  always @(posedge clk) if (frame_done) done_cnt++;

  typedef struct {
    bit         rst;
    logic [7:0] fill;
    int         a1;
    logic [7:0] v1;
    int         a2;
    logic [7:0] v2;
    bit         oob;
    logic [7:0] th;
    logic [15:0] e_led;
    logic [3:0]  e_band;
    logic [7:0]  e_lvl;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [15:0] e_led, input logic [3:0] e_band,
                         input logic [7:0] e_lvl);
    chk({nm, " led"}, 32'(led), 32'(e_led));
    chk({nm, " peak_band"}, 32'(peak_band), 32'(e_band));
    chk({nm, " peak_level"}, 32'(peak_level), 32'(e_lvl));
  endtask

  task automatic do_reset(input string nm);
    reset_n = 1'b0;
    tick();
    tick();
    chk_out(nm, 16'h0, 4'd0, 8'h00);
    chk({nm, " frame_done"}, 32'(frame_done), 0);
    chk({nm, " busy"}, 32'(busy), 0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic feed(input logic [7:0] fill, input int a1, input logic [7:0] v1,
                      input int a2, input logic [7:0] v2, input bit oob,
                      input bit fs_first, input bit fs_last);
    if (fs_first) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    if (oob) begin
      for (int a = 512; a < 1024; a += 31) begin
        freq_valid = 1'b1; freq_addr = 10'(a); freq_data = 8'hFF;
        tick();
      end
      freq_addr = 10'd1023;
      tick();
    end
    for (int a = 0; a < 512; a++) begin
      freq_valid  = 1'b1;
      freq_addr   = 10'(a);
      freq_data   = (a == a1) ? v1 : (a == a2) ? v2 : fill;
      frame_start = fs_last && (a == 511);
      tick();
    end
    freq_valid  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int fs_at);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      frame_start = (n == fs_at);
      tick();
      frame_start = 1'b0;
      if (n == 1) chk({nm, " busy in commit"}, 32'(busy), 1);
      if (frame_done) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    chk({nm, " done latency"}, seen ? 32'(lat) : 32'd99, 17);
    chk({nm, " busy after done"}, 32'(busy), 0);
    tick();
    chk({nm, " done width"}, 32'(frame_done), 0);
  endtask

  initial begin
    int base;
    vecs[0] = '{1, 8'h20, 37,  8'hF0, -1,  8'h00, 0, 8'h30, 16'h0002, 4'd1, 8'hF0};
    vecs[1] = '{0, 8'h00, -1,  8'h00, -1,  8'h00, 0, 8'h1B, 16'hFFFF, 4'd1, 8'hEC};
    vecs[2] = '{0, 8'h00, -1,  8'h00, -1,  8'h00, 0, 8'h1C, 16'h0002, 4'd1, 8'hE8};
    vecs[3] = '{1, 8'h02, -1,  8'h00, -1,  8'h00, 0, 8'h00, 16'hFFFF, 4'd0, 8'h02};
    vecs[4] = '{0, 8'h00, -1,  8'h00, -1,  8'h00, 0, 8'h00, 16'h0000, 4'd0, 8'h00};
    vecs[5] = '{0, 8'h00, 0,   8'hFF, -1,  8'h00, 1, 8'h00, 16'h0000, 4'd0, 8'h00};
    vecs[6] = '{0, 8'h00, 101, 8'h80, 288, 8'h80, 0, 8'h7F, 16'h0208, 4'd3, 8'h80};
    vecs[7] = '{0, 8'h00, -1,  8'h00, -1,  8'h00, 0, 8'h7B, 16'h0208, 4'd3, 8'h7C};

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      if (vecs[i].rst) do_reset({nm, " reset"});
      thresh = vecs[i].th;
      feed(vecs[i].fill, vecs[i].a1, vecs[i].v1, vecs[i].a2, vecs[i].v2, vecs[i].oob, 1'b1, 1'b0);
      wait_done(nm, 0);
      chk_out(nm, vecs[i].e_led, vecs[i].e_band, vecs[i].e_lvl);
    end

    // Restart mid-frame: the 0xFF partial frame must vanish without a frame_done.
    do_reset("restart reset");
    thresh = 8'h0F;
    base = done_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int a = 0; a <= 200; a++) begin
      freq_valid = 1'b1; freq_addr = 10'(a); freq_data = 8'hFF;
      tick();
    end
    freq_valid = 1'b0;
    feed(8'h10, -1, 8'h00, -1, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("restart no early done", 32'(done_cnt - base), 0);
    wait_done("restart", 0);
    chk_out("restart", 16'hFFFF, 4'd0, 8'h10);

    // Start during COMMIT, then start coinciding with the last bin: both chain straight into ACCUM.
    thresh = 8'h2F;
    feed(8'h30, -1, 8'h00, -1, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_done("pend commit", 3);
    chk_out("pend commit", 16'hFFFF, 4'd0, 8'h30);
    feed(8'h00, 300, 8'h90, -1, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_done("pend chained", 0);
    chk_out("pend chained", 16'h0200, 4'd9, 8'h90);
    thresh = 8'h4F;
    feed(8'h50, -1, 8'h00, -1, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_done("pend lastbin", 0);
    chk_out("pend lastbin", 16'hFFFF, 4'd9, 8'h8C);

    // Reset while COMMIT is on band 8.
    thresh = 8'h00;
    feed(8'h60, -1, 8'h00, -1, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 8; n++) tick();
    chk("midreset busy before", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk_out("midreset", 16'h0, 4'd0, 8'h00);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset frame_done", 32'(frame_done), 0);
    tick();
    reset_n = 1'b1;
    base = done_cnt;
    for (int n = 0; n < 30; n++) tick();
    chk("midreset no done", 32'(done_cnt - base), 0);
    feed(8'h00, -1, 8'h00, -1, 8'h00, 1'b0, 1'b1, 1'b0);
    wait_done("after midreset", 0);
    chk_out("after midreset", 16'h0000, 4'd0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
